snake_game_ctrl: RTL
====================

Name: snake_game_ctrl

Overview:
- Sequencer for the snake playfield datapath. Generates the one-cycle `start` and `step` strobes, latches the player's direction request between steps, and supplies a free-running pseudo-random apple seed.
- Tracks game state: idle, running, paused and game-over. Detects death from the field's `snake_alive` flag and freezes the field.
- Sits between the button/debounce logic and the playfield. Its outputs drive the field's `start`, `step`, `snake_dir` and `seed` inputs directly.

Parameters:
- STEP_PERIOD, 24'd5000000: clock cycles between consecutive step strobes (game speed); legal range >= 2.
- SIZE_X, 8'd10: playfield width; used only to size SBITS.
- SIZE_Y, 8'd10: playfield height; used only to size SBITS.
- SBITS, $clog2(SIZE_X*SIZE_Y): seed width.
- CBITS, 16: width of the survived-step counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- btn_start  input  1  start/restart button, debounced level
- btn_dir  input  4  direction buttons, debounced levels; bit0 up, bit1 right, bit2 down, bit3 left
- snake_alive  input  1  field flag: 1 = the next move with the current direction is legal
- field_start  output  1  one-cycle strobe to the field's start input
- field_step  output  1  one-cycle strobe to the field's step input
- snake_dir  output  2  latched direction: 0 up, 1 right, 2 down, 3 left
- seed  output  SBITS  LFSR value for apple placement
- game_over  output  1  high in state OVER
- running  output  1  high in state RUN
- step_count  output  CBITS  steps survived this game, saturating

Behaviour:
- Reset: every output and internal register takes its reset value in the cycle rst is sampled high. Reset has priority over all other inputs, including mid-game; state returns to IDLE.
  - Reset values: field_start=0, field_step=0, snake_dir=1, game_over=0, running=0, step_count=0, tick counter=0, LFSR=1, btn_start edge register=0.
- Start edge: `start_rise = btn_start & ~btn_start_q`, where btn_start_q is btn_start registered once. A held button yields exactly one event.
- FSM states: IDLE, INIT, RUN, OVER (PAUSE only with the optional feature).
  - IDLE: on start_rise go to INIT; otherwise stay.
  - INIT: for exactly one cycle, register field_start=1, snake_dir=1 (right), tick counter=0 and step_count=0; then go to RUN.
  - RUN: the tick counter counts 0..STEP_PERIOD-1 and wraps to 0. At terminal count:
    - snake_alive=1: pulse field_step for one cycle, and increment step_count (holds at all-ones).
    - snake_alive=0: no step; go to OVER.
    - snake_alive is sampled only in the terminal cycle.
  - RUN: start_rise is ignored.
  - OVER: game_over=1, no strobes; on start_rise go to INIT.
- Strobes are registered outputs, high for exactly one cycle. field_start and field_step are never high in the same cycle.
- Direction latch:
  - Sampled every cycle in RUN.
  - If any btn_dir bit is set, snake_dir takes the lowest-numbered set bit (priority up > right > down > left).
  - If no bit is set, snake_dir holds.
  - A reversal (e.g. left while moving right) is passed through unchanged; the field rejects it.
  - snake_dir is frozen outside RUN, except that INIT forces it to 1.
- Seed:
  - Free-running Galois LFSR of width max(SBITS,3), stepping every cycle in every state, never stuck at 0.
  - seed = low SBITS bits of the LFSR.
  - An SBITS=7 bench uses taps x^7+x^6+1 (period 127).

Optional Feature:
- Macro SNAKE_CTRL_PAUSE_EN.
- Defined:
  - Adds input btn_pause (1 bit, debounced level) with its own rising-edge detector.
  - In RUN, a btn_pause rising edge goes to PAUSE. In PAUSE, a btn_pause rising edge returns to RUN.
  - In PAUSE: the tick counter holds its value, snake_dir holds, running=0, there are no strobes, and start_rise is ignored.
  - If a pause edge coincides with the RUN terminal tick, the step and alive check are performed first and the next state is PAUSE (or OVER if dead).
- Undefined: no port, no PAUSE state, identical behaviour otherwise.

Decomposition:
- Shared package snake_pkg:
  - Direction encodings DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3.
  - State encodings for IDLE/INIT/RUN/OVER/PAUSE.
  - LFSR tap constants per width.
- One natural sub-module: snake_lfsr (parameter WIDTH; ports clk, rst, value), reusable by the field's apple placer.

Test Plan:
- Reset and start, STEP_PERIOD=4: rst 2 cycles, then raise btn_start → field_start high exactly 1 cycle. The first field_step comes 4 cycles after entering RUN, then every 4 cycles. snake_dir=1.
- Hold btn_start 20 cycles in RUN → no second field_start; step_count increments by 1 per step (value 5 after 5 steps).
- Death: snake_alive=0 at a terminal tick → no field_step that cycle, game_over=1 next cycle, no further strobes. A btn_start edge then gives field_start=1 and step_count=0.
- Direction: btn_dir=4'b1100 for 1 cycle → snake_dir=2. Then btn_dir=0 → snake_dir stays 2 across 3 steps.
- Seed: from reset, seed never 0 and no repeat within 127 cycles (SBITS=7).
- SNAKE_CTRL_PAUSE_EN: pause edge at tick count 2 → no field_step for 50 cycles. A second pause edge → next field_step after exactly 1 more tick (the counter resumed from 2).

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake controller and playfield: directions, game
// states and Galois LFSR tap masks.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_OVER  = 3'd3,
        ST_PAUSE = 3'd4
    } state_e;

    // Right-shifting Galois masks of maximal-length polynomials, indexed by width.
    function automatic logic [31:0] lfsrTaps(input int width);
        case (width)
            3:       lfsrTaps = 32'h0000_0006;
            4:       lfsrTaps = 32'h0000_000C;
            5:       lfsrTaps = 32'h0000_0014;
            6:       lfsrTaps = 32'h0000_0030;
            7:       lfsrTaps = 32'h0000_0060;
            8:       lfsrTaps = 32'h0000_00B8;
            9:       lfsrTaps = 32'h0000_0110;
            10:      lfsrTaps = 32'h0000_0240;
            11:      lfsrTaps = 32'h0000_0500;
            12:      lfsrTaps = 32'h0000_0E08;
            13:      lfsrTaps = 32'h0000_1C80;
            14:      lfsrTaps = 32'h0000_3802;
            15:      lfsrTaps = 32'h0000_6000;
            16:      lfsrTaps = 32'h0000_D008;
            default: lfsrTaps = (32'h1 << (width - 1)) | (32'h1 << (width - 2));
        endcase
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the button/field side (master) and the controller
// (slave). btn_pause exists only when SNAKE_CTRL_PAUSE_EN is defined.
interface snake_game_ctrl_if #(
    parameter int SBITS = 7,
    parameter int CBITS = 16
);
    logic             btn_start;
    logic [3:0]       btn_dir;
    logic             snake_alive;
`ifdef SNAKE_CTRL_PAUSE_EN
    logic             btn_pause;
`endif
    logic             field_start;
    logic             field_step;
    logic [1:0]       snake_dir;
    logic [SBITS-1:0] seed;
    logic             game_over;
    logic             running;
    logic [CBITS-1:0] step_count;

    modport master (
`ifdef SNAKE_CTRL_PAUSE_EN
        output btn_pause,
`endif
        output btn_start, btn_dir, snake_alive,
        input  field_start, field_step, snake_dir, seed, game_over, running, step_count
    );

    modport slave (
`ifdef SNAKE_CTRL_PAUSE_EN
        input  btn_pause,
`endif
        input  btn_start, btn_dir, snake_alive,
        output field_start, field_step, snake_dir, seed, game_over, running, step_count
    );
endinterface

// File: rtl/snake_lfsr.sv
// Free-running Galois LFSR, reset to 1 so it can never lock up at zero.
module snake_lfsr
    import snake_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsrTaps(WIDTH));

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= WIDTH'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;
endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: start/step strobes, direction latch, apple seed.
// Define SNAKE_CTRL_PAUSE_EN to add the btn_pause input and PAUSE state.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter logic [23:0] STEP_PERIOD = 24'd5000000,
    parameter logic [7:0]  SIZE_X      = 8'd10,
    parameter logic [7:0]  SIZE_Y      = 8'd10,
    parameter int          SBITS       = $clog2(int'(SIZE_X) * int'(SIZE_Y)),
    parameter int          CBITS       = 16
) (
    input logic              clk,
    input logic              rst,
    snake_game_ctrl_if.slave bus
);
    localparam int LBITS = (SBITS > 3) ? SBITS : 3;

    state_e           state_q;
    logic [23:0]      tick_q;
    dir_e             dir_q;
    dir_e             dir_d;
    logic [CBITS-1:0] stepCnt_q;
    logic             fieldStart_q;
    logic             fieldStep_q;
    logic             startPrev_q;
    logic [LBITS-1:0] lfsrValue;

    logic             startRise;
    logic             terminal;
    logic             pauseRise;

    assign startRise = bus.btn_start & ~startPrev_q;
    assign terminal  = (tick_q == STEP_PERIOD - 24'd1);

`ifdef SNAKE_CTRL_PAUSE_EN
    logic pausePrev_q;

    assign pauseRise = bus.btn_pause & ~pausePrev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pausePrev_q <= 1'b0;
        end else begin
            pausePrev_q <= bus.btn_pause;
        end
    end
`else
    assign pauseRise = 1'b0;
`endif

    // Lowest-numbered pressed button wins; no press keeps the current heading.
    always_comb begin
        dir_d = dir_q;
        if (bus.btn_dir[0]) begin
            dir_d = DIR_UP;
        end else if (bus.btn_dir[1]) begin
            dir_d = DIR_RIGHT;
        end else if (bus.btn_dir[2]) begin
            dir_d = DIR_DOWN;
        end else if (bus.btn_dir[3]) begin
            dir_d = DIR_LEFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            dir_q        <= DIR_RIGHT;
            stepCnt_q    <= '0;
            fieldStart_q <= 1'b0;
            fieldStep_q  <= 1'b0;
            startPrev_q  <= 1'b0;
        end else begin
            startPrev_q  <= bus.btn_start;
            fieldStart_q <= 1'b0;
            fieldStep_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (startRise) state_q <= ST_INIT;
                end
                ST_INIT: begin
                    fieldStart_q <= 1'b1;
                    dir_q        <= DIR_RIGHT;
                    tick_q       <= '0;
                    stepCnt_q    <= '0;
                    state_q      <= ST_RUN;
                end
                ST_RUN: begin
                    dir_q  <= dir_d;
                    tick_q <= terminal ? 24'd0 : tick_q + 24'd1;
                    if (terminal && bus.snake_alive) begin
                        fieldStep_q <= 1'b1;
                        if (stepCnt_q != '1) stepCnt_q <= stepCnt_q + 1'b1;
                    end
                    // Death outranks a coincident pause request.
                    if (terminal && !bus.snake_alive) begin
                        state_q <= ST_OVER;
                    end else if (pauseRise) begin
                        state_q <= ST_PAUSE;
                    end
                end
                ST_OVER: begin
                    if (startRise) state_q <= ST_INIT;
                end
                ST_PAUSE: begin
                    if (pauseRise) state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    snake_lfsr #(
        .WIDTH (LBITS)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsrValue)
    );

    assign bus.field_start = fieldStart_q;
    assign bus.field_step  = fieldStep_q;
    assign bus.snake_dir   = dir_q;
    assign bus.seed        = lfsrValue[SBITS-1:0];
    assign bus.game_over   = (state_q == ST_OVER);
    assign bus.running     = (state_q == ST_RUN);
    assign bus.step_count  = stepCnt_q;
endmodule
